regbank_arbiter: RTL
====================

# regbank_arbiter

Round-robin write arbiter sharing one bank of CE-gated, asynchronously cleared registers (the FDCPE-style storage of the TF0060DCA testsuite) between several requesters. Each requester presents an address/data pair with a level request. The block grants one requester at a time and drives a single write through the bank's per-register clock enables. It returns a one-cycle acknowledge and completes a four-phase release before re-arbitrating.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, register data width
- NREG, 8, registers in the bank (1..16)
- AW, 3, requester address width; AW ≥ clog2(NREG)

- C  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high; clears every register in the block
- CE  in  1  global clock enable; low freezes all state
- req  in  NREQ  level write request per requester
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, held from latch through release
- ack  out  NREQ  one-cycle write-done pulse to the granted requester
- reg_ce  out  NREG  one-hot clock enable to the register bank
- reg_d  out  DW  data to the register bank (shared D bus)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, ACK, RELEASE. Reset state is IDLE. Reset pointer ptr = 0.
- IDLE, any req bit set: the winner is the first set bit scanning from ptr upward, with wrap-around. On that edge:
  - gnt ← onehot(winner)
  - lat_addr ← winner's addr
  - reg_d ← winner's wdata
  - go to WRITE.
- IDLE, no request: outputs stay at their reset values.
- WRITE: reg_ce[lat_addr] = state==WRITE && CE. Go to ACK.
  - If lat_addr ≥ NREG, no reg_ce bit is set, but the sequence still completes with an ack.
- ACK: ack[winner] = state==ACK && CE. On the edge, ptr ← (winner+1) mod NREQ, then go to RELEASE.
- RELEASE: gnt is held. When req[winner]==0, gnt ← 0 and go to IDLE. Other requests are ignored until then.
- Requests from non-granted requesters are never lost. They stay pending as levels and are arbitrated on the next IDLE.
- CE low: state, ptr, gnt, reg_d, lat_addr all hold. reg_ce and ack are forced low, so no duplicate write or ack occurs during a freeze.
- CLR asserted at any point, including mid-WRITE:
  - immediately: gnt=0, ack=0, reg_ce=0, reg_d=0, busy=0, ptr=0, state=IDLE
  - an interrupted write is not retried.
- Reset values of all outputs: 0.

## Timing
- Request sampled at edge k in IDLE:
  - gnt valid after k
  - reg_ce high for cycle k..k+1 (the bank captures at k+1)
  - ack high for cycle k+1..k+2
  - RELEASE from k+2.
- Minimum occupancy is 4 cycles per transaction (requester drops req during the ack cycle), so the next grant is at edge k+4 at the earliest.
- All outputs are Moore-style: decoded from registered state and gated only by CE. There is no combinational path from req, addr or wdata to any output.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,3,0,… Worst-case wait is NREQ-1 transactions.

## Structure
- Shared package/include regbank_pkg:
  - state encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_ACK=2'd2, ST_RELEASE=2'd3
  - clog2 function
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NREQ], ptr.
  - Outputs: winner index, any.
- The FSM, latches and CE/ack decoders stay in regbank_arbiter.
- The register bank itself (FDCPE instances) is outside this block.

## Test plan
- Reset: CLR=1 with req=4'b1111 → all outputs 0, busy=0. After CLR falls, first grant goes to requester 0.
- Single write: req[2]=1, addr[2]=5, wdata[2]=8'hA5.
  - Expected: gnt=4'b0100 at k; reg_ce=8'b0010_0000 with reg_d=8'hA5 for one cycle; ack[2] one cycle later.
  - Return to IDLE one cycle after req[2] drops.
- Round robin: req=4'b1111 held; each requester drops req after its ack and re-raises it next cycle → grant order 0,1,2,3,0 and exactly one reg_ce pulse per transaction.
- CE freeze: drop CE for 3 cycles while in WRITE → reg_ce=0 during the freeze, exactly one reg_ce pulse total, ack follows the resumed WRITE.
- Out-of-range address: NREG=6, addr=7 → no reg_ce bit set, ack still pulses, ptr advances.
- Mid-transaction reset: assert CLR during ACK → ack drops immediately, state=IDLE, ptr=0. A still-pending req re-arbitrates from requester 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   state_t : arbiter FSM state encoding
//   clog2   : ceiling log2 used to size index and pointer fields
package regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req    : request levels, one bit per requester
//   ptr    : requester with highest priority this round
//   winner : first set request scanning upward from ptr, wrapping
//   any    : at least one request is set
module rr_pick
    import regbank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    logic [NREQ-1:0] keep_mask;
    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pool;

    always_comb begin
        // Requests at or above ptr take precedence; only when none exist
        // does the search wrap to the low end, which is then just the
        // lowest set bit of the full request vector.
        keep_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
        upper     = req & keep_mask;
        pool      = (upper != '0) ? upper : req;
        winner    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                winner = PW'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin write arbiter for a shared bank of
// CE-gated, asynchronously cleared registers.
//   C      : clock, rising edge
//   CLR    : asynchronous active-high clear of all state
//   CE     : global clock enable; low freezes state and masks pulses
//   req    : level write requests, one per requester
//   addr   : packed requester addresses, requester i at [i*AW +: AW]
//   wdata  : packed requester data, requester i at [i*DW +: DW]
//   gnt    : one-hot grant, held from latch through release
//   ack    : one-cycle write-done pulse to the granted requester
//   reg_ce : one-hot clock enable into the register bank
//   reg_d  : shared data bus into the register bank
//   busy   : arbiter is not idle
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              C,
    input  logic              CLR,
    input  logic              CE,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [NREG-1:0]   reg_ce,
    output logic [DW-1:0]     reg_d,
    output logic              busy
);

    localparam int PW = clog2(NREQ);

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   win_reg, win_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [AW-1:0]   lat_addr_reg, lat_addr_next;
    logic [DW-1:0]   reg_d_reg, reg_d_next;

    logic [PW-1:0]   pick_win;
    logic            pick_any;
    logic            write_en;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            win_reg      <= '0;
            gnt_reg      <= '0;
            lat_addr_reg <= '0;
            reg_d_reg    <= '0;
        end else if (CE) begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            win_reg      <= win_next;
            gnt_reg      <= gnt_next;
            lat_addr_reg <= lat_addr_next;
            reg_d_reg    <= reg_d_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        win_next      = win_reg;
        gnt_next      = gnt_reg;
        lat_addr_next = lat_addr_reg;
        reg_d_next    = reg_d_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    win_next      = pick_win;
                    gnt_next      = NREQ'(1) << pick_win;
                    lat_addr_next = addr[int'(pick_win)*AW +: AW];
                    reg_d_next    = wdata[int'(pick_win)*DW +: DW];
                    state_next    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = ST_ACK;
            end
            ST_ACK: begin
                // The requester after the one just served gets first look next time.
                ptr_next   = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + PW'(1);
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Four-phase handshake: hold the grant until the winner lets go.
                if (!req[win_reg]) begin
                    gnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pulses are masked by CE so a frozen WRITE or ACK cycle does not
    // repeat the register write or the acknowledge.
    assign write_en = (state_reg == ST_WRITE) && CE;

    // An address beyond the bank matches no bit, so the write is dropped
    // while the handshake still completes.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_ce
        assign reg_ce[gi] = write_en && (lat_addr_reg == AW'(gi));
    end

    assign ack   = ((state_reg == ST_ACK) && CE) ? gnt_reg : '0;
    assign gnt   = gnt_reg;
    assign reg_d = reg_d_reg;
    assign busy  = (state_reg != ST_IDLE);

endmodule
